// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the decoder/controller and the PC sequencer.
// No handshake: the sequencer consumes op/cond/target/offset every cycle stall is low.
interface pc_sequencer_if #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic              stall;
  logic [2:0]        op;
  logic              cond;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] pc;
  logic [SP_W-1:0]   sp;
  logic              stack_empty;
  logic              stack_full;
  logic              ovf;
  logic              unf;

  modport master (
    output stall, op, cond, target, offset,
    input  pc, sp, stack_empty, stack_full, ovf, unf
  );

  modport slave (
    input  stall, op, cond, target, offset,
    output pc, sp, stack_empty, stack_full, ovf, unf
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: step, jump, conditional relative branch, and
// call/return through a small hardware return-address stack.
module pc_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_sequencer_if.slave bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_SEQ    = 3'b000;
  localparam logic [2:0] OP_JUMP   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  // Power-of-two sized so any IDX_W-bit index is in range; extra slots unused.
  logic [ADDR_W-1:0] stack_mem [2**IDX_W];

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              push;
  logic              empty, full;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  assign pc_inc = pc_q + ADDR_W'(1);
  assign empty  = (sp_q == '0);
  assign full   = (sp_q == SP_W'(STACK_DEPTH));
  assign wr_idx = IDX_W'(sp_q);
  assign rd_idx = IDX_W'(sp_q - SP_W'(1));

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (!bus.stall) begin
      pc_d = pc_inc;
      case (bus.op)
        OP_SEQ:    pc_d = pc_inc;
        OP_JUMP:   pc_d = bus.target;
        OP_BRANCH: if (bus.cond) pc_d = pc_q + bus.offset;
        OP_CALL: begin
          if (!full) begin
            push = 1'b1;
            sp_d = sp_q + SP_W'(1);
            pc_d = bus.target;
          end else begin
            ovf_d = 1'b1;
          end
        end
        OP_RET: begin
          if (!empty) begin
            pc_d = stack_mem[rd_idx];
            sp_d = sp_q - SP_W'(1);
          end else begin
            unf_d = 1'b1;
          end
        end
        default: pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_ADDR;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack contents are not reset; only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (rst_n && push) stack_mem[wr_idx] <= pc_inc;
  end

  assign bus.pc          = pc_q;
  assign bus.sp          = sp_q;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;
  assign bus.ovf         = ovf_q;
  assign bus.unf         = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (ADDR_W=8, STACK_DEPTH=4, RESET_ADDR=0).
module tb_pc_sequencer;
  localparam logic [2:0] SEQ = 3'b000, JMP = 3'b001, BRN = 3'b010,
                         CAL = 3'b011, RET = 3'b100;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  pc_sequencer_if #(.ADDR_W(8), .STACK_DEPTH(4)) bus ();

  pc_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_ADDR(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one op across one rising edge, then settle for sampling.
  task automatic step(input logic [2:0] op, input logic [7:0] tgt, input logic [7:0] off,
                      input logic c, input logic st, input logic rn);
    @(negedge clk);
    rst_n      = rn;
    bus.op     = op;
    bus.target = tgt;
    bus.offset = off;
    bus.cond   = c;
    bus.stall  = st;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [2:0] op, input logic [7:0] tgt, input logic [7:0] off,
                     input logic c);
    step(op, tgt, off, c, 1'b0, 1'b1);
  endtask

  task automatic chk(input string tag, input logic [7:0] pc, input logic [2:0] sp,
                     input logic ovf, input logic unf);
    check_val({tag, ".pc"},    32'(bus.pc),          32'(pc));
    check_val({tag, ".sp"},    32'(bus.sp),          32'(sp));
    check_val({tag, ".ovf"},   32'(bus.ovf),         32'(ovf));
    check_val({tag, ".unf"},   32'(bus.unf),         32'(unf));
    check_val({tag, ".empty"}, 32'(bus.stack_empty), 32'(sp == 3'd0));
    check_val({tag, ".full"},  32'(bus.stack_full),  32'(sp == 3'd4));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.op = SEQ; bus.target = '0; bus.offset = '0; bus.cond = 1'b0; bus.stall = 1'b0;

    // reset overrides stall and op
    step(JMP, 8'h40, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("reset", 8'h00, 3'd0, 1'b0, 1'b0);

    // sequential steps and stall
    run(SEQ, 0, 0, 0); chk("seq1", 8'h01, 3'd0, 0, 0);
    run(SEQ, 0, 0, 0); chk("seq2", 8'h02, 3'd0, 0, 0);
    run(SEQ, 0, 0, 0); chk("seq3", 8'h03, 3'd0, 0, 0);
    step(JMP, 8'h40, 8'h00, 1'b0, 1'b1, 1'b1); chk("stall1", 8'h03, 3'd0, 0, 0);
    step(JMP, 8'h40, 8'h00, 1'b0, 1'b1, 1'b1); chk("stall2", 8'h03, 3'd0, 0, 0);
    run(JMP, 8'hFF, 0, 0); chk("jmp_ff", 8'hFF, 3'd0, 0, 0);
    run(SEQ, 0, 0, 0);     chk("wrap", 8'h00, 3'd0, 0, 0);

    // branches
    run(JMP, 8'h10, 0, 0);     chk("jmp_10", 8'h10, 3'd0, 0, 0);
    run(BRN, 0, 8'hFC, 1'b1);  chk("brn_back", 8'h0C, 3'd0, 0, 0);
    run(BRN, 0, 8'h05, 1'b0);  chk("brn_not", 8'h0D, 3'd0, 0, 0);
    run(BRN, 0, 8'h00, 1'b1);  chk("brn_self", 8'h0D, 3'd0, 0, 0);
    run(BRN, 0, 8'h05, 1'b1);  chk("brn_fwd", 8'h12, 3'd0, 0, 0);
    run(JMP, 8'hA0, 0, 0);     chk("jmp_a0", 8'hA0, 3'd0, 0, 0);

    // nested calls
    run(JMP, 8'h20, 0, 0); chk("jmp_20", 8'h20, 3'd0, 0, 0);
    run(CAL, 8'h50, 0, 0); chk("call1", 8'h50, 3'd1, 0, 0);
    run(CAL, 8'h60, 0, 0); chk("call2", 8'h60, 3'd2, 0, 0);
    step(RET, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1); chk("stall_ret", 8'h60, 3'd2, 0, 0);
    run(RET, 0, 0, 0);     chk("ret1", 8'h51, 3'd1, 0, 0);
    run(RET, 0, 0, 0);     chk("ret2", 8'h21, 3'd0, 0, 0);

    // overflow
    run(JMP, 8'h80, 0, 0); chk("jmp_80", 8'h80, 3'd0, 0, 0);
    run(CAL, 8'h90, 0, 0); chk("ocall1", 8'h90, 3'd1, 0, 0);
    run(CAL, 8'hA0, 0, 0); chk("ocall2", 8'hA0, 3'd2, 0, 0);
    run(CAL, 8'hB0, 0, 0); chk("ocall3", 8'hB0, 3'd3, 0, 0);
    run(CAL, 8'hC0, 0, 0); chk("ocall4", 8'hC0, 3'd4, 0, 0);
    run(CAL, 8'hD0, 0, 0); chk("ocall5", 8'hC1, 3'd4, 1, 0);
    run(RET, 0, 0, 0);     chk("oret1", 8'hB1, 3'd3, 1, 0);
    run(RET, 0, 0, 0);     chk("oret2", 8'hA1, 3'd2, 1, 0);
    run(RET, 0, 0, 0);     chk("oret3", 8'h91, 3'd1, 1, 0);
    run(RET, 0, 0, 0);     chk("oret4", 8'h81, 3'd0, 1, 0);

    // back-to-back call/return
    run(CAL, 8'h40, 0, 0); chk("b2b_call1", 8'h40, 3'd1, 1, 0);
    run(RET, 0, 0, 0);     chk("b2b_ret1", 8'h82, 3'd0, 1, 0);
    run(CAL, 8'h44, 0, 0); chk("b2b_call2", 8'h44, 3'd1, 1, 0);
    run(RET, 0, 0, 0);     chk("b2b_ret2", 8'h83, 3'd0, 1, 0);

    // underflow and reserved ops
    run(JMP, 8'h30, 0, 0);   chk("jmp_30", 8'h30, 3'd0, 1, 0);
    run(RET, 0, 0, 0);       chk("unf_ret", 8'h31, 3'd0, 1, 1);
    run(3'b111, 8'hEE, 0, 1); chk("op111", 8'h32, 3'd0, 1, 1);
    run(3'b101, 8'hEE, 0, 1); chk("op101", 8'h33, 3'd0, 1, 1);

    // reset in the middle of a nest
    run(CAL, 8'h10, 0, 0); chk("rcall1", 8'h10, 3'd1, 1, 1);
    run(CAL, 8'h20, 0, 0); chk("rcall2", 8'h20, 3'd2, 1, 1);
    run(CAL, 8'h77, 0, 0); chk("rcall3", 8'h77, 3'd3, 1, 1);
    step(CAL, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0); chk("mid_reset", 8'h00, 3'd0, 0, 0);
    run(RET, 0, 0, 0);     chk("post_reset_ret", 8'h01, 3'd0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the RISC core, replacing the fixed 4-bit counter. It generates the instruction fetch address each cycle from a small operation code: sequential step, absolute jump, conditional PC-relative branch, subroutine call and return. Call/return use an internal hardware return-address stack. The block sits between the decoder/controller, which drives `op`, `target`, `offset` and `cond`, and instruction memory, which is addressed by `pc`.

## Interface
- `ADDR_W`, 8, PC / instruction address width (≥2)
- `STACK_DEPTH`, 4, return-address stack entries (≥1)
- `RESET_ADDR`, 0, PC value after reset (ADDR_W bits)
- `SP_W`, $clog2(STACK_DEPTH+1), width of `sp` (derived, not overridden)

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst_n`  in  1  synchronous, active-low reset; sampled on rising `clk`
- `stall`  in  1  hold all state this cycle
- `op`  in  3  000 SEQ, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET; 101–111 treated as SEQ
- `cond`  in  1  branch condition, used by BRANCH only
- `target`  in  ADDR_W  absolute destination for JUMP/CALL
- `offset`  in  ADDR_W  two's-complement displacement for BRANCH
- `pc`  out  ADDR_W  current instruction address (registered)
- `sp`  out  SP_W  number of valid stack entries, 0..STACK_DEPTH
- `stack_empty`  out  1  `sp == 0`
- `stack_full`  out  1  `sp == STACK_DEPTH`
- `ovf`  out  1  sticky: a CALL was made while the stack was full
- `unf`  out  1  sticky: a RET was made while the stack was empty

## Operation
- Reset (`rst_n`=0 at an edge):
  - `pc`=RESET_ADDR, `sp`=0, `ovf`=`unf`=0.
  - `stack_empty`=1, `stack_full`=0.
  - Stack RAM contents are not cleared (don't care).
  - Reset overrides `stall` and `op`.
- `stall`=1, not in reset: `pc`, `sp`, stack contents and flags hold; `op` is ignored (not queued).
- Otherwise, per `op` (all arithmetic modulo 2^ADDR_W, wrap silently):
  - SEQ: `pc` ← `pc`+1.
  - JUMP: `pc` ← `target`.
  - BRANCH: `cond`=1 → `pc` ← `pc`+sign(`offset`); `cond`=0 → `pc`+1. `offset`=0 taken is a legal self-loop.
  - CALL, not full: write `pc`+1 at stack[`sp`], `sp` ← `sp`+1, `pc` ← `target`.
  - CALL, full: no push, no jump; `pc` ← `pc`+1; `ovf` ← 1.
  - RET, not empty: `pc` ← stack[`sp`-1], `sp` ← `sp`-1.
  - RET, empty: `pc` ← `pc`+1; `unf` ← 1.
  - Reserved ops 101–111: identical to SEQ, no flag change.
- `ovf`/`unf` clear only on reset; once set they stay set.
- `stack_empty`/`stack_full` are combinational decodes of the registered `sp`.
- No FSM beyond the PC register, stack pointer and the two sticky flag bits.

## Timing
- All outputs are registered or decoded from registers; there is no combinational path from any input to any output.
- Latency is one cycle: `op` sampled at edge N takes effect on `pc`/`sp` immediately after edge N.
- Throughput is one operation per unstalled cycle. Back-to-back CALL/RET is legal:
  - A RET in the cycle after a CALL returns the address just pushed.
  - A CALL in the cycle after a RET reuses the freed slot.
- A reset asserted during any sequence (e.g. nested calls) takes effect at that edge; the next `op` executes from RESET_ADDR with an empty stack.
- `stall` and `rst_n` are sampled at the same edge as `op`.

## Test plan
All scenarios use ADDR_W=8, STACK_DEPTH=4, RESET_ADDR=0.
- Reset then 3× SEQ → `pc` 0,1,2,3; hold `stall`=1 with `op`=JUMP,`target`=0x40 for 2 cycles → `pc` stays 3; at `pc`=0xFF, SEQ → `pc`=0x00.
- At `pc`=0x10: BRANCH `offset`=0xFC,`cond`=1 → `pc`=0x0C; BRANCH `offset`=0x05,`cond`=0 → `pc`=0x0D; JUMP `target`=0xA0 → `pc`=0xA0.
- Nested calls: at `pc`=0x20, CALL 0x50 then CALL 0x60 → `sp`=2, `pc`=0x60; RET → `pc`=0x51; RET → `pc`=0x21, `sp`=0, `stack_empty`=1.
- Overflow: 4 CALLs → `stack_full`=1; 5th CALL at `pc`=P → `pc`=P+1, `sp`=4, `ovf`=1; 4 RETs unwind in correct LIFO order; `ovf` remains 1.
- Underflow: with `sp`=0 at `pc`=0x30, RET → `pc`=0x31, `unf`=1; op=111 → behaves as SEQ, `pc`=0x32.
- Reset mid-nest: with `sp`=3 and `pc`=0x77, assert `rst_n`=0 together with `op`=CALL → next state `pc`=0, `sp`=0, `ovf`=`unf`=0.
